// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter that shares one 4:1 single-bit mux among
// four requesters. The mux select (address1/address0) and the one-hot grants
// come from registers, so the select cannot glitch between clock edges.
// A hold-limit counter stops one requester from keeping the mux while others
// wait.
//
// Request/grant protocol: a requester raises reqN and keeps it high for as long
// as it wants the mux. grantN rises one edge after the request wins. Dropping
// reqN releases the mux at the next edge. Pulses between edges are never seen.
//
// Ports:
//   clk                     rising-edge clock
//   reset                   synchronous, active-high reset
//   req0..req3              request lines of requesters 0..3
//   grant0..grant3          registered grants, one-hot or all zero
//   address1, address0      registered mux select = owner index (00 when idle)
//   busy                    registered, high while any grant is high
//   hold_count[7:0]         cycles the current owner has held the grant (0 idle)
//   dbg_state_o             FSM state (0 = IDLE, 1 = GRANT)
//   dbg_ptr_o[1:0]          round-robin priority pointer
module mux_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       req2,
    input  logic       req3,
    output logic       grant0,
    output logic       grant1,
    output logic       grant2,
    output logic       grant3,
    output logic       address0,
    output logic       address1,
    output logic       busy,
    output logic [7:0] hold_count,
    output logic       dbg_state_o,
    output logic [1:0] dbg_ptr_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;   // doubles as the mux select
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] grant_q, grant_d;
    logic       busy_q, busy_d;

    logic [3:0] req;
    logic [3:0] cand;
    logic [1:0] scan_ptr;
    logic       win_found;
    logic [1:0] win_idx;

    assign req = {req3, req2, req1, req0};

    // First set candidate found scanning scan_ptr, scan_ptr+1, ... (mod 4).
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!win_found && cand[scan_ptr + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = scan_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        cand     = req;
        scan_ptr = ptr_q;

        if (state_q == IDLE) begin
            // Grant out of IDLE leaves the pointer alone.
            if (win_found) begin
                state_d = GRANT;
                owner_d = win_idx;
                hold_d  = 8'd1;
            end
        end else if (!req[owner_q]) begin
            // Release: rotate past the owner, hand over with no dead cycle.
            ptr_d    = owner_q + 2'd1;
            scan_ptr = owner_q + 2'd1;
            if (win_found) begin
                owner_d = win_idx;
                hold_d  = 8'd1;
            end else begin
                state_d = IDLE;
                owner_d = 2'd0;
                hold_d  = 8'd0;
            end
        end else if (hold_q == 8'(MAX_HOLD)) begin
            // Timeout: the owner is excluded; if nobody else wants the mux
            // it is re-granted with a fresh count.
            ptr_d          = owner_q + 2'd1;
            scan_ptr       = owner_q + 2'd1;
            cand[owner_q]  = 1'b0;
            owner_d        = win_found ? win_idx : owner_q;
            hold_d         = 8'd1;
        end else begin
            hold_d = hold_q + 8'd1;
        end

        // Grants, select and busy are all derived from the same next state,
        // so they always change together.
        busy_d  = (state_d == GRANT);
        grant_d = busy_d ? (4'b0001 << owner_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= 8'd0;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign grant0      = grant_q[0];
    assign grant1      = grant_q[1];
    assign grant2      = grant_q[2];
    assign grant3      = grant_q[3];
    assign address0    = owner_q[0];
    assign address1    = owner_q[1];
    assign busy        = busy_q;
    assign hold_count  = hold_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: two instances (MAX_HOLD 8 and 4) driven by the same
// requests, compared each cycle against a behavioural model of the
// arbitration rules, plus literal expectations for the directed scenarios.
module tb_mux_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] req;

    logic [3:0] g_a, g_b;
    logic       a0_a, a1_a, a0_b, a1_b;
    logic       busy_a, busy_b;
    logic [7:0] hold_a, hold_b;
    logic       st_a, st_b;
    logic [1:0] ptr_a, ptr_b;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    mux_arbiter dut_a (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
        .grant0(g_a[0]), .grant1(g_a[1]), .grant2(g_a[2]), .grant3(g_a[3]),
        .address0(a0_a), .address1(a1_a), .busy(busy_a), .hold_count(hold_a),
        .dbg_state_o(st_a), .dbg_ptr_o(ptr_a)
    );

    mux_arbiter #(.MAX_HOLD(4)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
        .grant0(g_b[0]), .grant1(g_b[1]), .grant2(g_b[2]), .grant3(g_b[3]),
        .address0(a0_b), .address1(a1_b), .busy(busy_b), .hold_count(hold_b),
        .dbg_state_o(st_b), .dbg_ptr_o(ptr_b)
    );

    // ---------------- reference model ----------------
    int m_max[2] = '{8, 4};
    bit m_busy[2];
    int m_owner[2];
    int m_ptr[2];
    int m_hold[2];

    function automatic int rr_scan(input logic [3:0] r, input int p, input int excl);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (p + k) % 4;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input int m);
        int w;
        if (reset) begin
            m_busy[m] = 0; m_owner[m] = 0; m_ptr[m] = 0; m_hold[m] = 0;
        end else if (!m_busy[m]) begin
            w = rr_scan(req, m_ptr[m], -1);
            if (w >= 0) begin
                m_busy[m] = 1; m_owner[m] = w; m_hold[m] = 1;
            end
        end else if (!req[m_owner[m]]) begin
            m_ptr[m] = (m_owner[m] + 1) % 4;
            w = rr_scan(req, m_ptr[m], -1);
            if (w >= 0) begin
                m_owner[m] = w; m_hold[m] = 1;
            end else begin
                m_busy[m] = 0; m_owner[m] = 0; m_hold[m] = 0;
            end
        end else if (m_hold[m] == m_max[m]) begin
            m_ptr[m] = (m_owner[m] + 1) % 4;
            w = rr_scan(req, m_ptr[m], m_owner[m]);
            if (w >= 0) m_owner[m] = w;
            m_hold[m] = 1;
        end else begin
            m_hold[m] = m_hold[m] + 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input int m, input logic [3:0] g, input logic [1:0] ad,
                             input logic b, input logic [7:0] h, input logic st,
                             input logic [1:0] p);
        logic [3:0] eg;
        eg = m_busy[m] ? (4'b0001 << m_owner[m]) : 4'b0000;
        check($sformatf("grant[%0d]", m), 32'(g), 32'(eg));
        check($sformatf("address[%0d]", m), 32'(ad), m_busy[m] ? 32'(m_owner[m]) : 32'd0);
        check($sformatf("busy[%0d]", m), 32'(b), 32'(m_busy[m]));
        check($sformatf("hold[%0d]", m), 32'(h), 32'(m_hold[m]));
        check($sformatf("state[%0d]", m), 32'(st), 32'(m_busy[m]));
        check($sformatf("ptr[%0d]", m), 32'(p), 32'(m_ptr[m]));
    endtask

    // ---------------- driver ----------------
    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_dut(0, g_a, {a1_a, a0_a}, busy_a, hold_a, st_a, ptr_a);
        check_dut(1, g_b, {a1_b, a0_b}, busy_b, hold_b, st_b, ptr_b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        cycle();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        @(negedge clk);

        // Reset with all requests high
        cycle();
        cycle();
        check("rst_grant", 32'(g_a), 32'h0);
        check("rst_hold", 32'(hold_a), 32'h0);
        reset = 1'b0;
        cycle();
        check("post_rst_grant", 32'(g_a), 32'h1);
        check("post_rst_addr", 32'({a1_a, a0_a}), 32'h0);

        // Single requester 2 for 5 cycles (MAX_HOLD 8 instance)
        do_reset();
        req = 4'b0100;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check("single_grant", 32'(g_a), 32'h4);
            check("single_addr", 32'({a1_a, a0_a}), 32'h2);
            check("single_hold", 32'(hold_a), 32'(i));
        end
        req = 4'b0000;
        cycle();
        check("single_idle_busy", 32'(busy_a), 32'h0);

        // Rotation: req0 and req3, req0 drops after 3 grant cycles
        do_reset();
        req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rot_grant0", 32'(g_a), 32'h1);
        end
        req = 4'b1000;
        cycle();
        check("rot_grant3", 32'(g_a), 32'h8);
        req = 4'b0000;
        cycle();
        check("rot_ptr0", 32'(ptr_a), 32'h0);
        req = 4'b0011;
        cycle();
        check("rot_new_grant0", 32'(g_a), 32'h1);

        // Timeout with req1 and req2 contending (MAX_HOLD 4 instance)
        do_reset();
        req = 4'b0110;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("tmo_grant", 32'(g_b), ((i / 4) % 2 == 0) ? 32'h2 : 32'h4);
            check("tmo_hold", 32'(hold_b), 32'((i % 4) + 1));
        end

        // Timeout with a sole requester
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("sole_grant", 32'(g_b), 32'h8);
            check("sole_hold", 32'(hold_b), 32'((i % 4) + 1));
        end

        // Reset mid-grant with hold_count 3
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 3; i++) cycle();
        check("mid_hold3", 32'(hold_a), 32'h3);
        req   = 4'b0011;
        reset = 1'b1;
        cycle();
        check("mid_rst_grant", 32'(g_a), 32'h0);
        check("mid_rst_ptr", 32'(ptr_a), 32'h0);
        reset = 1'b0;
        cycle();
        check("mid_after_grant0", 32'(g_a), 32'h1);

        // Randomized persistent requests with occasional reset
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < 4; r++) begin
                if ($urandom_range(3, 0) == 0) req[r] = ~req[r];
            end
            reset = ($urandom_range(63, 0) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
